// File: rtl/count_cam_client.sv
// rtl/count_cam_client.sv - sequencing client for the sp_cnt CAM (search / increment)
//
// Accepts one SEARCH or INC request at a time, drives the CAM search/write
// pulses, collects the CAM result and returns it through a valid/ready
// response port. A round-robin victim pointer supplies the replacement index
// for searches and is reported as the response index on a miss.
//
// Sizing macros normally come from parameters.vh (N_ENTRY, BANK_BITS,
// SP_CNT_BIT); local defaults apply when they are not already defined.
// Optional feature macro: CAM_CLIENT_TIMEOUT_EN adds a CAM watchdog that
// returns rsp_err_o=1 after N_ENTRY+8 cycles without a CAM result.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i/req_ready_o      request handshake
//   req_op_i                     0 = SEARCH, 1 = INC
//   req_sp_cnt_i/idx_i/bank_i    request payload
//   cam_search_o/cam_write_o     one-cycle CAM command pulses
//   cam_sp_cnt_o/inc_idx_o/bank_id_o  held CAM operands
//   cam_addr_idx_i/is_hit_i/valid_i   CAM result
//   rsp_valid_o/rsp_ready_i      response handshake
//   rsp_hit_o/rsp_idx_o/rsp_err_o     response payload
`ifndef N_ENTRY
`define N_ENTRY 8
`endif
`ifndef BANK_BITS
`define BANK_BITS 4
`endif
`ifndef SP_CNT_BIT
`define SP_CNT_BIT 8
`endif

module count_cam_client (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic                          req_op_i,
    input  logic [`SP_CNT_BIT-1:0]        req_sp_cnt_i,
    input  logic [$clog2(`N_ENTRY)-1:0]   req_idx_i,
    input  logic [$clog2(`BANK_BITS)-1:0] req_bank_i,
    output logic                          cam_search_o,
    output logic                          cam_write_o,
    output logic [`SP_CNT_BIT-1:0]        cam_sp_cnt_o,
    output logic [$clog2(`N_ENTRY)-1:0]   cam_inc_idx_o,
    output logic [$clog2(`BANK_BITS)-1:0] cam_bank_id_o,
    input  logic [$clog2(`N_ENTRY)-1:0]   cam_addr_idx_i,
    input  logic                          cam_is_hit_i,
    input  logic                          cam_valid_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_hit_o,
    output logic [$clog2(`N_ENTRY)-1:0]   rsp_idx_o,
    output logic                          rsp_err_o
);
    localparam int IW = $clog2(`N_ENTRY);

    typedef enum logic [2:0] {
        IDLE, ISSUE_S, WAIT_S, DRAIN, ISSUE_W, WR_WAIT, RESP
    } state_t;

    state_t          state, next_state;
    logic            wr_cnt;
    logic            res_hit;
    logic [IW-1:0]   res_idx;
    logic [IW-1:0]   victim;
    logic            capture;
    logic            timeout;
    logic            wd_expired;

`ifdef CAM_CLIENT_TIMEOUT_EN
    localparam int WD_LIMIT = `N_ENTRY + 8;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_cnt;

    // Expires on the WD_LIMIT-th cycle spent waiting on the CAM.
    assign wd_expired = (wd_cnt == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_cnt <= '0;
        end else if (state == ISSUE_S) begin
            wd_cnt <= '0;
        end else if (state == WAIT_S || state == DRAIN) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        req_ready_o  = 1'b0;
        cam_search_o = 1'b0;
        cam_write_o  = 1'b0;
        capture      = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) next_state = req_op_i ? ISSUE_W : ISSUE_S;
            end
            ISSUE_S: begin
                cam_search_o = 1'b1;
                next_state   = WAIT_S;
            end
            WAIT_S: begin
                if (cam_valid_i) begin
                    capture    = 1'b1;
                    next_state = DRAIN;
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    next_state = RESP;
                end
            end
            DRAIN: begin
                // The CAM may keep valid high for a second cycle on a miss;
                // those extra cycles are ignored.
                if (!cam_valid_i) begin
                    next_state = RESP;
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    next_state = RESP;
                end
            end
            ISSUE_W: begin
                cam_write_o = 1'b1;
                next_state  = WR_WAIT;
            end
            WR_WAIT: begin
                if (wr_cnt) next_state = RESP;
            end
            RESP: begin
                if (rsp_ready_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wr_cnt        <= 1'b0;
            res_hit       <= 1'b0;
            res_idx       <= '0;
            victim        <= '0;
            cam_sp_cnt_o  <= '0;
            cam_inc_idx_o <= '0;
            cam_bank_id_o <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_hit_o     <= 1'b0;
            rsp_idx_o     <= '0;
            rsp_err_o     <= 1'b0;
        end else begin
            state <= next_state;

            if (state == IDLE && req_valid_i) begin
                cam_sp_cnt_o  <= req_sp_cnt_i;
                cam_bank_id_o <= req_bank_i;
                cam_inc_idx_o <= req_op_i ? req_idx_i : victim;
                wr_cnt        <= 1'b0;
            end

            if (state == WR_WAIT) wr_cnt <= 1'b1;

            if (state == ISSUE_W) begin
                res_hit <= 1'b0;
                res_idx <= cam_inc_idx_o;
            end

            if (capture) begin
                res_hit <= cam_is_hit_i;
                res_idx <= cam_is_hit_i ? cam_addr_idx_i : victim;
            end

            // Victim advances only on a completed miss, so a watchdog abort
            // leaves it where it was.
            if (state == DRAIN && !cam_valid_i && !res_hit) begin
                victim <= (victim == IW'(`N_ENTRY - 1)) ? '0 : victim + 1'b1;
            end

            if (state != RESP && next_state == RESP) begin
                rsp_valid_o <= 1'b1;
                rsp_hit_o   <= timeout ? 1'b0 : res_hit;
                rsp_idx_o   <= timeout ? victim : res_idx;
                rsp_err_o   <= timeout;
            end else if (state == RESP && next_state == IDLE) begin
                rsp_valid_o <= 1'b0;
                rsp_hit_o   <= 1'b0;
                rsp_idx_o   <= '0;
                rsp_err_o   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_count_cam_client.sv
// tb/tb_count_cam_client.sv - directed self-checking bench for count_cam_client
`ifndef N_ENTRY
`define N_ENTRY 8
`endif
`ifndef BANK_BITS
`define BANK_BITS 4
`endif
`ifndef SP_CNT_BIT
`define SP_CNT_BIT 8
`endif

module tb_count_cam_client;
    localparam int IW = $clog2(`N_ENTRY);
    localparam int BW = $clog2(`BANK_BITS);

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic                   req_op = 1'b0;
    logic [`SP_CNT_BIT-1:0] req_sp_cnt = '0;
    logic [IW-1:0]          req_idx = '0;
    logic [BW-1:0]          req_bank = '0;
    logic                   cam_search, cam_write;
    logic [`SP_CNT_BIT-1:0] cam_sp_cnt;
    logic [IW-1:0]          cam_inc_idx;
    logic [BW-1:0]          cam_bank_id;
    logic [IW-1:0]          cam_addr = '0;
    logic                   cam_is_hit = 1'b0;
    logic                   cam_valid = 1'b0;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic                   rsp_hit;
    logic [IW-1:0]          rsp_idx;
    logic                   rsp_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_cam_client dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_sp_cnt_i(req_sp_cnt), .req_idx_i(req_idx), .req_bank_i(req_bank),
        .cam_search_o(cam_search), .cam_write_o(cam_write),
        .cam_sp_cnt_o(cam_sp_cnt), .cam_inc_idx_o(cam_inc_idx), .cam_bank_id_o(cam_bank_id),
        .cam_addr_idx_i(cam_addr), .cam_is_hit_i(cam_is_hit), .cam_valid_i(cam_valid),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx), .rsp_err_o(rsp_err)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SEARCH transaction. The CAM holds valid 1 cycle on a hit and 2 on a
    // miss; the second miss cycle carries a bogus hit so a recapture shows up.
    task automatic run_search(input logic hit, input logic [IW-1:0] addr,
                              input logic [IW-1:0] exp_vic, input logic [IW-1:0] exp_idx);
        int pulses;
        pulses     = 0;
        req_valid  = 1'b1;
        req_op     = 1'b0;
        req_sp_cnt = 8'd3;
        req_bank   = 2'd1;
        chk("s_req_ready_idle", req_ready, 1);
        cyc();
        req_valid = 1'b0;
        pulses += int'(cam_search);
        chk("s_write_low", cam_write, 0);
        chk("s_victim_out", cam_inc_idx, exp_vic);
        chk("s_sp_cnt_out", cam_sp_cnt, 3);
        cyc();
        pulses += int'(cam_search);
        cam_valid  = 1'b1;
        cam_is_hit = hit;
        cam_addr   = addr;
        cyc();
        pulses += int'(cam_search);
        if (!hit) begin
            cam_is_hit = 1'b1;
            cam_addr   = ~addr;
            cyc();
            pulses += int'(cam_search);
        end
        cam_valid  = 1'b0;
        cam_is_hit = 1'b0;
        cam_addr   = '0;
        cyc();
        chk("s_rsp_valid", rsp_valid, 1);
        chk("s_rsp_hit", rsp_hit, hit);
        chk("s_rsp_idx", rsp_idx, exp_idx);
        chk("s_rsp_err", rsp_err, 0);
        chk("s_search_pulses", pulses, 1);
        chk("s_req_ready_busy", req_ready, 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("s_rsp_valid_clr", rsp_valid, 0);
        chk("s_rsp_idx_clr", rsp_idx, 0);
        chk("s_req_ready_back", req_ready, 1);
    endtask

    initial begin
        logic [IW-1:0] hold_idx;
        logic          stable;
        int            n;

        // Reset state
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_search", cam_search, 0);
        chk("rst_write", cam_write, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_idx", rsp_idx, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cam_inc_idx", cam_inc_idx, 0);
        chk("rst_cam_sp_cnt", cam_sp_cnt, 0);

        // Hit at entry 5, victim stays 0; then misses walk the victim
        run_search(1'b1, 3'd5, 3'd0, 3'd5);
        run_search(1'b0, 3'd6, 3'd0, 3'd0);
        run_search(1'b0, 3'd6, 3'd1, 3'd1);
        for (int i = 2; i < `N_ENTRY; i++) run_search(1'b0, 3'd4, IW'(i), IW'(i));
        // Ninth consecutive miss wraps to 0
        run_search(1'b0, 3'd4, 3'd0, 3'd0);

        // INC idx 7 bank 2
        req_valid  = 1'b1;
        req_op     = 1'b1;
        req_idx    = 3'd7;
        req_bank   = 2'd2;
        req_sp_cnt = 8'd9;
        cyc();
        req_valid = 1'b0;
        chk("w_write_pulse", cam_write, 1);
        chk("w_search_low", cam_search, 0);
        chk("w_inc_idx", cam_inc_idx, 7);
        chk("w_bank_id", cam_bank_id, 2);
        cyc();
        chk("w_write_once", cam_write, 0);
        cyc();
        chk("w_no_rsp_yet", rsp_valid, 0);
        cyc();
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_rsp_idx", rsp_idx, 7);
        chk("w_rsp_hit", rsp_hit, 0);

        // Backpressure for 10 cycles
        stable   = 1'b1;
        hold_idx = rsp_idx;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (rsp_valid !== 1'b1 || rsp_idx !== hold_idx || rsp_hit !== 1'b0 ||
                rsp_err !== 1'b0 || req_ready !== 1'b0 || cam_inc_idx !== 3'd7 ||
                cam_bank_id !== 2'd2) stable = 1'b0;
        end
        chk("bp_stable", stable, 1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        chk("bp_released", rsp_valid, 0);

        // Reset while in WAIT_S aborts with no response
        req_valid = 1'b1;
        req_op    = 1'b0;
        cyc();
        req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("ar_req_ready", req_ready, 1);
        chk("ar_rsp_valid", rsp_valid, 0);
        cyc();
        rst = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) stable = 1'b0;
        end
        chk("ar_no_rsp", stable, 1);
        // Victim was 1 before reset; reset must return it to 0
        run_search(1'b1, 3'd2, 3'd0, 3'd2);

        // CAM never answers
        req_valid = 1'b1;
        req_op    = 1'b0;
        cyc();
        req_valid = 1'b0;
        n = 0;
        cyc();
`ifdef CAM_CLIENT_TIMEOUT_EN
        while (rsp_valid !== 1'b1 && n < 100) begin
            n++;
            cyc();
        end
        chk("to_wait_cycles", n, `N_ENTRY + 8);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_hit", rsp_hit, 0);
        chk("to_rsp_idx", rsp_idx, 0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        run_search(1'b0, 3'd3, 3'd0, 3'd0);
`else
        stable = 1'b1;
        while (n < 40) begin
            n++;
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b0) stable = 1'b0;
            cyc();
        end
        chk("nto_waits", stable, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        run_search(1'b0, 3'd3, 3'd0, 3'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/count_cam_client.md
COUNT_CAM_CLIENT -- requirements
Module: count_cam_client

Interface
REQ-001 SHALL use macros from parameters.vh: N_ENTRY (CAM entries), BANK_BITS (banks per entry vector), SP_CNT_BIT (count width); IW = clog2(N_ENTRY), BW = clog2(BANK_BITS).
REQ-002 SHALL declare these ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  upstream request
- req_ready_o  out  1  client can accept a request
- req_op_i  in  1  0 = SEARCH, 1 = INC
- req_sp_cnt_i  in  SP_CNT_BIT  count to search
- req_idx_i  in  IW  entry for INC
- req_bank_i  in  BW  requesting bank
- cam_search_o  out  1  CAM search pulse
- cam_write_o  out  1  CAM write pulse
- cam_sp_cnt_o  out  SP_CNT_BIT  CAM sp_cnt_i
- cam_inc_idx_o  out  IW  CAM inc_idx_i
- cam_bank_id_o  out  BW  CAM bank_id_i
- cam_addr_idx_i  in  IW  CAM address_idx_o
- cam_is_hit_i  in  1  CAM is_hit_o
- cam_valid_i  in  1  CAM valid_o
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  downstream accepts result
- rsp_hit_o  out  1  search hit
- rsp_idx_o  out  IW  hit index, victim index, or INC index
- rsp_err_o  out  1  CAM timeout

Function
REQ-003 SHALL implement FSM states IDLE, ISSUE_S, WAIT_S, DRAIN, ISSUE_W, WR_WAIT, RESP.
REQ-004 req_ready_o SHALL be 1 only in IDLE; a handshake (req_valid_i and req_ready_o) SHALL latch op, sp_cnt, idx, and bank, then go to ISSUE_S (op 0) or ISSUE_W (op 1).
REQ-005 cam_sp_cnt_o, cam_bank_id_o, and cam_inc_idx_o SHALL be registered and held stable from ISSUE_* until the return to IDLE.
REQ-006 SEARCH: cam_inc_idx_o SHALL equal the victim pointer; ISSUE_S SHALL assert cam_search_o for exactly one cycle, then go to WAIT_S.
REQ-007 WAIT_S: on the first cycle with cam_valid_i=1, SHALL capture hit=cam_is_hit_i, idx=cam_addr_idx_i on hit or the victim pointer on miss, then go to DRAIN.
REQ-008 On miss, SHALL advance the victim pointer by 1 with wrap N_ENTRY-1 -> 0; it SHALL NOT change on hit.
REQ-009 DRAIN SHALL wait until cam_valid_i=0 (the CAM holds valid for 1 cycle on hit, 2 on miss), then go to RESP; further valid cycles SHALL NOT be recaptured.
REQ-010 INC: ISSUE_W SHALL assert cam_write_o for one cycle, with cam_inc_idx_o=req_idx_i latched.
REQ-011 INC: WR_WAIT SHALL hold for 2 cycles, then go to RESP with hit=0, idx=latched idx.
REQ-012 cam_search_o and cam_write_o SHALL never be high together and SHALL be 0 outside ISSUE_S/ISSUE_W.
REQ-013 RESP SHALL hold rsp_valid_o=1 with stable rsp_* until rsp_ready_i=1, then go to IDLE; back-to-back requests SHALL therefore have at least 1 IDLE cycle between them.
REQ-014 rsp_* outputs SHALL be registered; rsp_hit_o, rsp_idx_o, and rsp_err_o SHALL be 0 outside RESP.

Reset
REQ-015 rst_i SHALL asynchronously force IDLE, victim pointer 0, watchdog 0, all latched fields 0, and all outputs 0 except req_ready_o=1 after release.
REQ-016 Reset mid-transaction SHALL abort it with no response; the first request after release SHALL be serviced normally.

Configuration
REQ-017 With CAM_CLIENT_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT_S/DRAIN, cleared on entry to WAIT_S.
REQ-018 If the watchdog reaches N_ENTRY+8, the FSM SHALL go to RESP with rsp_err_o=1, hit=0, and idx=victim pointer, and the victim pointer SHALL NOT advance.
REQ-019 Without CAM_CLIENT_TIMEOUT_EN, there SHALL be no watchdog logic, rsp_err_o SHALL be tied 0, and WAIT_S SHALL wait indefinitely.

Verification
REQ-020 Search hit: CAM model hits sp_cnt=3 at entry 5 -> exactly one cam_search_o pulse; rsp_hit_o=1, rsp_idx_o=5, rsp_err_o=0; victim pointer unchanged.
REQ-021 Search miss: CAM valid held 2 cycles, is_hit=0, victim=0 -> rsp_hit_o=0, rsp_idx_o=0, single capture; next miss gives rsp_idx_o=1.
REQ-022 Victim wrap: N_ENTRY consecutive misses followed by one more miss -> the last rsp_idx_o is 0.
REQ-023 INC idx=7, bank=2: one cam_write_o pulse with cam_inc_idx_o=7 and cam_bank_id_o=2 -> RESP 3 cycles later with rsp_idx_o=7, rsp_hit_o=0.
REQ-024 Backpressure and reset: rsp_ready_i held low 10 cycles -> rsp_* stable and req_ready_o=0 throughout. Reset asserted in WAIT_S -> immediately IDLE with no rsp_valid_o.
REQ-025 With CAM_CLIENT_TIMEOUT_EN: CAM never returns valid -> rsp_err_o=1 after N_ENTRY+8 cycles in WAIT_S. Without the macro: rsp_err_o stays 0.
